// File: rtl/result_drain.sv
// -----------------------------------------------------------------------------
// result_drain
//
// Purpose:
//   Streams a block of words out of an output SRAM. An accepted run captures a
//   base address and a word count. The block then reads base_addr + n for
//   n = 0 .. num_words-1 and presents each word on a valid/ready stream. The
//   final beat of each drain is flagged with out_last. A 2-entry FIFO absorbs
//   consumer backpressure. Reads are credit-limited so that the FIFO can never
//   overflow, and with out_ready held high the stream still sustains one beat
//   per cycle.
//
// Ports:
//   clk                    sole clock, rising edge
//   reset                  asynchronous, active-low reset
//   run                    start request; sampled only while busy = 0
//   busy                   high from the accepted run until the last beat is
//                          accepted
//   base_addr              first SRAM address, captured on the accepted run
//   num_words              number of words to drain, captured on the accepted
//                          run
//   dut_sram_read_address  SRAM read address; holds its last value when idle
//   sram_dut_read_data     SRAM read data, valid the cycle after its address
//   out_valid              stream valid; equals "FIFO non-empty"
//   out_ready              stream ready; a beat moves when valid & ready
//   out_data               stream word
//   out_last               high on the final beat of a drain
//   checksum               (optional) modulo-2^DATA_WIDTH sum of accepted beats
//   checksum_valid         (optional) one-cycle pulse in DONE
//
// Build option:
//   RESULT_DRAIN_CHECKSUM_EN  when defined, adds checksum / checksum_valid.
// -----------------------------------------------------------------------------
module result_drain #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  output logic                  busy,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] num_words,
  output logic [ADDR_WIDTH-1:0] dut_sram_read_address,
  input  logic [DATA_WIDTH-1:0] sram_dut_read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
`ifdef RESULT_DRAIN_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic                  checksum_valid
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] FIFO_DEPTH = 2'd2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   next_addr_q, next_addr_d;  // next address to issue
  logic [ADDR_WIDTH-1:0]   remain_q, remain_d;        // addresses still to issue
  logic [ADDR_WIDTH-1:0]   last_addr_q;               // last issued address
  logic                    rd_pend_q;                 // read data arrives this cycle
  logic                    rd_pend_last_q;            // ...and it is the final word

  // 2-entry FIFO
  logic [DATA_WIDTH-1:0]   fifo_data_q [2];
  logic [1:0]              fifo_last_q;
  logic                    wr_ptr_q, rd_ptr_q;
  logic [1:0]              count_q, count_d;

  // ---------------------------------------------------------------------------
  // Handshake / credit logic
  // ---------------------------------------------------------------------------
  logic                    accept;
  logic                    push;
  logic                    pop;
  logic                    issue;
  logic                    issue_last;
  logic [1:0]              occupancy;
  logic                    head_last;
  logic [DATA_WIDTH-1:0]   head_data;

  assign accept    = (state_q == IDLE) && run;
  assign push      = rd_pend_q;
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign head_data = fifo_data_q[rd_ptr_q];
  assign head_last = fifo_last_q[rd_ptr_q];

  // Words already in the FIFO plus the one read whose data is on the SRAM bus
  // now. The head leaving this cycle frees its slot for the read issued now,
  // which is what lets the pipeline sustain one beat per cycle. The count plus
  // the pending read never exceeds 2, so this cannot underflow or overflow.
  assign occupancy  = count_q + {1'b0, rd_pend_q};
  assign issue      = (state_q == READ) &&
                      ((occupancy - {1'b0, pop}) < FIFO_DEPTH);
  assign issue_last = issue && (remain_q == {{(ADDR_WIDTH-1){1'b0}}, 1'b1});

  // The address is presented in the cycle the read is issued, so the SRAM
  // returns it on the following cycle and it lands in the FIFO at that
  // cycle's end. When no read is issued, the last address is held.
  assign dut_sram_read_address = issue ? next_addr_q : last_addr_q;

  // The outputs read as zero when the FIFO is empty. They then match their
  // reset values regardless of the stale storage contents.
  assign out_data = out_valid ? head_data : '0;
  assign out_last = out_valid && head_last;

  // busy covers the accepting cycle itself. This makes a zero-length run
  // visible for exactly one cycle before DONE.
  assign busy = accept || (state_q == READ) || (state_q == FLUSH);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    remain_d    = remain_q;

    case (state_q)
      IDLE: begin
        if (run) begin
          next_addr_d = base_addr;
          remain_d    = num_words;
          state_d     = (num_words == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (issue) begin
          // Natural wrap of the adder gives modulo-2^ADDR_WIDTH addressing.
          next_addr_d = next_addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          remain_d    = remain_q - {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          if (issue_last) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (pop && head_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      next_addr_q    <= '0;
      remain_q       <= '0;
      last_addr_q    <= '0;
      rd_pend_q      <= 1'b0;
      rd_pend_last_q <= 1'b0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
      fifo_last_q    <= 2'b00;
    end else begin
      state_q        <= state_d;
      next_addr_q    <= next_addr_d;
      remain_q       <= remain_d;
      rd_pend_q      <= issue;
      rd_pend_last_q <= issue_last;
      count_q        <= count_d;
      if (issue) begin
        last_addr_q <= next_addr_q;
      end
      if (push) begin
        wr_ptr_q              <= ~wr_ptr_q;
        fifo_last_q[wr_ptr_q] <= rd_pend_last_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // FIFO data storage needs no reset. Emptiness is tracked by count_q, and the
  // outputs are masked while the FIFO is empty.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_q == 1'(gi))) begin
        fifo_data_q[gi] <= sram_dut_read_data;
      end
    end
  end

`ifdef RESULT_DRAIN_CHECKSUM_EN
  // ---------------------------------------------------------------------------
  // Running checksum of accepted beats
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] checksum_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= '0;
    end else if (pop) begin
      checksum_q <= checksum_q + out_data;
    end
  end

  assign checksum       = checksum_q;
  assign checksum_valid = (state_q == DONE);
`endif

endmodule

// File: tb/tb_result_drain.sv
// -----------------------------------------------------------------------------
// tb_result_drain
//
// Directed testbench for result_drain. It uses a synchronous-read SRAM model
// in which mem[a] = a, so every expected word equals its address.
// -----------------------------------------------------------------------------
module tb_result_drain;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        busy;
  logic [11:0] base_addr;
  logic [11:0] num_words;
  logic [11:0] dut_sram_read_address;
  logic [15:0] sram_dut_read_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
`ifdef RESULT_DRAIN_CHECKSUM_EN
  logic [15:0] checksum;
  logic        checksum_valid;
`endif

  result_drain #(
    .ADDR_WIDTH(12),
    .DATA_WIDTH(16)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .run                   (run),
    .busy                  (busy),
    .base_addr             (base_addr),
    .num_words             (num_words),
    .dut_sram_read_address (dut_sram_read_address),
    .sram_dut_read_data    (sram_dut_read_data),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .out_data              (out_data),
    .out_last              (out_last)
`ifdef RESULT_DRAIN_CHECKSUM_EN
    ,
    .checksum              (checksum),
    .checksum_valid        (checksum_valid)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read SRAM: data is valid the cycle after the address.
  logic [15:0] mem [4096];
  always @(posedge clk) sram_dut_read_data <= mem[dut_sram_read_address];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [15:0] got_data [$];
  logic        got_last [$];
  int          got_idx  [$];
  int          done_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one run for one cycle and checks that busy covers the accepting
  // cycle. Afterwards the inputs are scrambled to show that they are ignored.
  task automatic start_run(input logic [11:0] b, input logic [11:0] n);
    @(negedge clk);
    run       = 1'b1;
    base_addr = b;
    num_words = n;
    #1;
    check("accept_busy", 32'(busy), 32'd1);
    @(negedge clk);
    run       = 1'b0;
    base_addr = ~b;
    num_words = 12'h007;
  endtask

  // Collects beats one cycle at a time.
  //   mode 0: out_ready = 1
  //   mode 1: out_ready = 1,0,0,1 repeating
  // hold_run keeps run high with junk operands while busy. stop_after > 0
  // returns after that many beats, without waiting for the drain to finish.
  task automatic collect(input int mode, input int stop_after, input bit hold_run, input int budget);
    logic        prev_stall;
    logic [15:0] prev_data;
    logic        prev_last;
    int          phase;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    got_data.delete();
    got_last.delete();
    got_idx.delete();
    done_idx = -1;
    for (int i = 0; i < budget; i++) begin
      phase     = i % 4;
      out_ready = (mode == 0) ? 1'b1 : ((phase == 0) || (phase == 3));
      run       = hold_run;
      if (hold_run) begin
        base_addr = 12'hABC;
        num_words = 12'h005;
      end
      #1;
      if (!busy) begin
        done_idx = i;
        break;
      end
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(prev_data));
        check("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        got_idx.push_back(i);
        $display("beat %0d: data=0x%04h last=%0b cycle=%0d", got_data.size() - 1, out_data, out_last, i);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      @(negedge clk);
      if ((stop_after > 0) && (got_data.size() == stop_after)) break;
    end
    run = 1'b0;
    if (stop_after == 0) check("drain_done", 32'(done_idx >= 0), 32'd1);
  endtask

  // Expected beat k comes from address b+k (mod 4096) and holds that value.
  task automatic verify_beats(input string tag, input logic [11:0] b, input int n);
    logic [11:0] a;
    check({tag, "_count"}, 32'(got_data.size()), 32'(n));
    for (int k = 0; k < got_data.size(); k++) begin
      a = b + 12'(k);
      check({tag, "_data"}, 32'(got_data[k]), 32'(a));
      check({tag, "_last"}, 32'(got_last[k]), 32'(k == n - 1));
    end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 16'(a);
    reset     = 1'b0;
    run       = 1'b0;
    out_ready = 1'b0;
    base_addr = '0;
    num_words = '0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_addr", 32'(dut_sram_read_address), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // 32 words, consumer always ready
    start_run(12'h000, 12'd32);
    collect(0, 0, 1'b0, 200);
    verify_beats("seq", 12'h000, 32);
    if (got_idx.size() == 32) begin
      check("first_latency_ge2", 32'(got_idx[0] >= 2), 32'd1);
      check("back_to_back", 32'(got_idx[31] - got_idx[0]), 32'd31);
      check("busy_fall", 32'(done_idx), 32'(got_idx[31] + 1));
    end
    check("addr_hold", 32'(dut_sram_read_address), 32'h01F);
`ifdef RESULT_DRAIN_CHECKSUM_EN
    check("csum_valid", 32'(checksum_valid), 32'd1);
    check("csum_value", 32'(checksum), 32'h01F0);
    @(negedge clk);
    #1;
    check("csum_pulse_end", 32'(checksum_valid), 32'd0);
`endif

    // Same data with backpressure; run is held high while busy and must be ignored.
    start_run(12'h000, 12'd32);
    collect(1, 0, 1'b1, 400);
    verify_beats("stall", 12'h000, 32);

    // Wrap across the top of the address space.
    start_run(12'hFFE, 12'd4);
    collect(0, 0, 1'b0, 100);
    verify_beats("wrap", 12'hFFE, 4);
    check("wrap_addr_hold", 32'(dut_sram_read_address), 32'h001);

    // Zero-length run: busy only during the accepting cycle.
    start_run(12'h123, 12'd0);
    for (int c = 0; c < 4; c++) begin
      #1;
      check("zero_busy", 32'(busy), 32'd0);
      check("zero_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
    end

    // Reset in the middle of a drain.
    start_run(12'h000, 12'd32);
    collect(0, 10, 1'b0, 200);
    check("pre_rst_beats", 32'(got_data.size()), 32'd10);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_last", 32'(out_last), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_addr", 32'(dut_sram_read_address), 32'd0);
    @(negedge clk);
    #1;
    check("in_rst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    start_run(12'h000, 12'd2);
    collect(0, 0, 1'b0, 50);
    verify_beats("post_rst", 12'h000, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
